// File: rtl/usb_pkg.sv
// Shared constants and types for the USB receive packet decoder.
// PID codes, FSM encoding, CRC16/CRC5 seeds and good residuals.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_PING  = 4'h4;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;
  localparam logic [3:0] PID_PRE   = 4'hC;
  localparam logic [3:0] PID_SPLIT = 4'h8;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_RES  = 16'hB001;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [4:0]  CRC5_RES   = 5'b01100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOKEN,
    S_DATA,
    S_HSK,
    S_DRAIN
  } state_t;

  typedef enum logic [2:0] {
    C_TOKEN,
    C_SOF,
    C_DATA,
    C_HSK,
    C_BAD
  } pid_class_t;

  function automatic pid_class_t pid_class(
    input logic [7:0] b
  );
    pid_class_t c;
    c = C_BAD;
    if (b[7:4] == ~b[3:0]) begin
      unique case (b[3:0])
        PID_OUT, PID_IN,
        PID_SETUP, PID_PING: c = C_TOKEN;
        PID_SOF:             c = C_SOF;
        PID_DATA0, PID_DATA1,
        PID_DATA2, PID_MDATA: c = C_DATA;
        PID_ACK, PID_NAK,
        PID_STALL, PID_NYET: c = C_HSK;
        PID_PRE, PID_SPLIT:  c = C_BAD;
        default:             c = C_BAD;
      endcase
    end
    return c;
  endfunction

  // Residual of the 16 token bits (11 field + 5 CRC), LSB first.
  function automatic logic [4:0] crc5_calc(
    input logic [15:0] bits
  );
    logic [4:0] c;
    c = CRC5_INIT;
    for (int i = 0; i < 16; i++) begin
      if (bits[i] ^ c[4])
        c = {c[3:0], 1'b0} ^ 5'h05;
      else
        c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide combinational CRC16 update (poly 0x8005, reflected, LSB first).
// Used by the packet decoder over all bytes following the PID.
module usb_crc16 (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i])
        c = (c >> 1) ^ 16'hA001;
      else
        c = c >> 1;
    end
  end

  assign crc_out = c;

endmodule

// File: rtl/usb_rx_packet.sv
// USB receive packet decoder: token/SOF/data/handshake classification.
// Optional USB_RX_CRC5_EN adds CRC5 checking of token and SOF packets.
module usb_rx_packet
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1024
) (
  input  logic        CLK_60M,
  input  logic        RST_USB,
  input  logic [7:0]  USB_DATA_OUT,
  input  logic        USB_DATA_OUT_STRB,
  input  logic        USB_DATA_OUT_END,
  input  logic        USB_DATA_OUT_FAIL,
  output logic [3:0]  PID,
  output logic        TOKEN_STRB,
  output logic [6:0]  TOKEN_ADDR,
  output logic [3:0]  TOKEN_ENDP,
  output logic        SOF_STRB,
  output logic [10:0] FRAME_NUM,
  output logic [7:0]  DATA_BYTE,
  output logic        DATA_STRB,
  output logic        DATA_END,
  output logic        DATA_ERR,
  output logic        HSK_STRB,
  output logic        PKT_ERR
);

  localparam int CW = $clog2(MAX_PAYLOAD + 4);

  state_t        state, st, nxt;
  pid_class_t    cls;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   crc, crc_n, crc_upd;
  logic [7:0]    h0, h1, h0_n, h1_n;
  logic          is_sof, sof_n;
  logic          tok_ok;
  logic [3:0]    pid_n;
  logic [7:0]    byte_n;
  logic [6:0]    addr_n;
  logic [3:0]    endp_n;
  logic [10:0]   frame_n;
  logic          tok_s, sof_s, dstrb_s;
  logic          dend_s, derr_s, hsk_s, perr_s;

  usb_crc16 u_crc16 (
    .crc_in  (crc),
    .data    (USB_DATA_OUT),
    .crc_out (crc_upd)
  );

  assign cls = pid_class(USB_DATA_OUT);

  always_comb begin
    st      = state;
    nxt     = state;
    cnt_n   = cnt;
    crc_n   = crc;
    h0_n    = h0;
    h1_n    = h1;
    sof_n   = is_sof;
    pid_n   = PID;
    byte_n  = DATA_BYTE;
    addr_n  = TOKEN_ADDR;
    endp_n  = TOKEN_ENDP;
    frame_n = FRAME_NUM;
    tok_ok  = 1'b0;
    tok_s   = 1'b0;
    sof_s   = 1'b0;
    dstrb_s = 1'b0;
    dend_s  = 1'b0;
    derr_s  = 1'b0;
    hsk_s   = 1'b0;
    perr_s  = 1'b0;
    if (USB_DATA_OUT_FAIL && state != S_IDLE) begin
      perr_s = 1'b1;
      derr_s = (state == S_DATA);
      nxt    = S_IDLE;
    end else begin
      if (USB_DATA_OUT_STRB) begin
        case (state)
          S_IDLE: begin
            cnt_n = '0;
            crc_n = CRC16_INIT;
            sof_n = (cls == C_SOF);
            if (cls == C_BAD) begin
              perr_s = 1'b1;
              st     = S_DRAIN;
            end else begin
              pid_n = USB_DATA_OUT[3:0];
              case (cls)
                C_TOKEN, C_SOF: st = S_TOKEN;
                C_DATA:         st = S_DATA;
                default:        st = S_HSK;
              endcase
            end
          end
          S_TOKEN: begin
            h0_n = h1;
            h1_n = USB_DATA_OUT;
            if (cnt != CW'(3))
              cnt_n = cnt + CW'(1);
          end
          S_DATA: begin
            if (cnt == CW'(MAX_PAYLOAD + 2)) begin
              derr_s = 1'b1;
              perr_s = 1'b1;
              st     = S_DRAIN;
            end else begin
              cnt_n = cnt + CW'(1);
              crc_n = crc_upd;
              h0_n  = h1;
              h1_n  = USB_DATA_OUT;
              // The two newest bytes may be CRC, so emit the one behind them.
              if (cnt >= CW'(2)) begin
                dstrb_s = 1'b1;
                byte_n  = h0;
              end
            end
          end
          S_HSK: begin
            perr_s = 1'b1;
            st     = S_DRAIN;
          end
          default: ;
        endcase
      end
      nxt = st;
      if (USB_DATA_OUT_END) begin
        case (st)
          S_TOKEN: begin
            nxt = S_IDLE;
`ifdef USB_RX_CRC5_EN
            tok_ok = (cnt_n == CW'(2)) &&
                     (crc5_calc({h1_n, h0_n}) == CRC5_RES);
`else
            tok_ok = (cnt_n == CW'(2));
`endif
            if (!tok_ok) begin
              perr_s = 1'b1;
            end else if (sof_n) begin
              sof_s   = 1'b1;
              frame_n = {h1_n[2:0], h0_n};
            end else begin
              tok_s  = 1'b1;
              addr_n = h0_n[6:0];
              endp_n = {h1_n[2:0], h0_n[7]};
            end
          end
          S_DATA: begin
            nxt = S_IDLE;
            if (cnt_n >= CW'(2) && crc_n == CRC16_RES) begin
              dend_s = 1'b1;
            end else begin
              derr_s = 1'b1;
              perr_s = 1'b1;
            end
          end
          S_HSK: begin
            nxt   = S_IDLE;
            hsk_s = 1'b1;
          end
          S_DRAIN: nxt = S_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      state      <= S_IDLE;
      cnt        <= '0;
      crc        <= CRC16_INIT;
      h0         <= '0;
      h1         <= '0;
      is_sof     <= 1'b0;
      PID        <= '0;
      TOKEN_STRB <= 1'b0;
      TOKEN_ADDR <= '0;
      TOKEN_ENDP <= '0;
      SOF_STRB   <= 1'b0;
      FRAME_NUM  <= '0;
      DATA_BYTE  <= '0;
      DATA_STRB  <= 1'b0;
      DATA_END   <= 1'b0;
      DATA_ERR   <= 1'b0;
      HSK_STRB   <= 1'b0;
      PKT_ERR    <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_n;
      crc        <= crc_n;
      h0         <= h0_n;
      h1         <= h1_n;
      is_sof     <= sof_n;
      PID        <= pid_n;
      TOKEN_STRB <= tok_s;
      TOKEN_ADDR <= addr_n;
      TOKEN_ENDP <= endp_n;
      SOF_STRB   <= sof_s;
      FRAME_NUM  <= frame_n;
      DATA_BYTE  <= byte_n;
      DATA_STRB  <= dstrb_s;
      DATA_END   <= dend_s;
      DATA_ERR   <= derr_s;
      HSK_STRB   <= hsk_s;
      PKT_ERR    <= perr_s;
    end
  end

endmodule
